// File: rtl/axi_compare_ctrl.sv
// Run controller for the AXI compare unit: AW/AR gating, drain, stats.
// Define AXI_COMPARE_CTRL_HALT_EN to stop a run on its first mismatch.
package axi_compare_ctrl_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  typedef struct packed {
    ax_t  aw;
    logic aw_valid;
    w_t   w;
    logic w_valid;
    logic b_ready;
    ax_t  ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;

  typedef struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    b_t   b;
    logic b_valid;
    r_t   r;
    logic r_valid;
  } axi_rsp_t;

endpackage

module axi_compare_ctrl #(
  parameter int unsigned AxiIdWidth   = 0,
  parameter int unsigned CntWidth     = 16,
  parameter int unsigned DrainTimeout = 1024,
  parameter type axi_req_t =
    axi_compare_ctrl_pkg::axi_req_t,
  parameter type axi_rsp_t =
    axi_compare_ctrl_pkg::axi_rsp_t
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  axi_req_t              slv_req_i,
  output axi_rsp_t              slv_rsp_o,
  output axi_req_t              mst_req_o,
  input  axi_rsp_t              mst_rsp_i,
  input  logic [2**AxiIdWidth-1:0] aw_mismatch_i,
  input  logic                  w_mismatch_i,
  input  logic [2**AxiIdWidth-1:0] b_mismatch_i,
  input  logic [2**AxiIdWidth-1:0] ar_mismatch_i,
  input  logic [2**AxiIdWidth-1:0] r_mismatch_i,
  input  logic                  mismatch_i,
  input  logic                  busy_i,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  timeout_o,
  output logic [CntWidth-1:0]   mismatch_cnt_o,
  output logic [4:0]            first_mismatch_o
);

  localparam int unsigned DW =
    (DrainTimeout > 1) ? $clog2(DrainTimeout) : 1;
  localparam logic [DW-1:0] DLast =
    DW'(DrainTimeout - 1);

  typedef enum logic [1:0] {
    Idle,
    Run,
    Drain,
    Done
  } state_e;

  state_e        state_q, state_d;
  logic          pend_aw_q, pend_ar_q;
  logic          aw_open, ar_open;
  logic          aw_fwd, ar_fwd;
  logic [DW-1:0] drain_q;
  logic          tmo_hit;
  logic          halt;
  logic          cnt_en;
  logic          clr_stats;
  logic [4:0]    snap;

  logic [CntWidth-1:0] cnt_q;
  logic                err_q;
  logic                tmo_q;
  logic [4:0]          first_q;

`ifdef AXI_COMPARE_CTRL_HALT_EN
  assign halt = mismatch_i;
`else
  assign halt = 1'b0;
`endif

  assign aw_open = (state_q == Run) | pend_aw_q;
  assign ar_open = (state_q == Run) | pend_ar_q;
  assign aw_fwd  = slv_req_i.aw_valid & aw_open;
  assign ar_fwd  = slv_req_i.ar_valid & ar_open;

  assign cnt_en    = (state_q == Run)
                   | (state_q == Drain);
  assign clr_stats = clear_i
                   & ((state_q == Idle)
                   |  (state_q == Done));

  assign snap = {|aw_mismatch_i,
                 w_mismatch_i,
                 |b_mismatch_i,
                 |ar_mismatch_i,
                 |r_mismatch_i};

  // Forward everything; only AW/AR valid/ready are gated.
  always_comb begin
    mst_req_o          = slv_req_i;
    slv_rsp_o          = mst_rsp_i;
    mst_req_o.aw_valid = aw_fwd;
    mst_req_o.ar_valid = ar_fwd;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_open;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_open;
  end

  // Next-state logic; timeout wins once the drain window is spent.
  always_comb begin
    state_d = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      Idle: begin
        if (start_i) state_d = Run;
      end
      Run: begin
        if (stop_i || halt) state_d = Drain;
      end
      Drain: begin
        if (drain_q == DLast) begin
          state_d = Done;
          tmo_hit = 1'b1;
        end else if (!busy_i && !pend_aw_q
                     && !pend_ar_q) begin
          state_d = Done;
        end
      end
      Done: begin
        if (clear_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  // Pending flags hold an offered AW/AR open until it handshakes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_aw_q <= 1'b0;
      pend_ar_q <= 1'b0;
    end else begin
      pend_aw_q <= aw_fwd & ~mst_rsp_i.aw_ready;
      pend_ar_q <= ar_fwd & ~mst_rsp_i.ar_ready;
    end
  end

  // Drain age counter, zero on every DRAIN entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                drain_q <= '0;
    else if (state_q == Drain)  drain_q <= drain_q + 1'b1;
    else                        drain_q <= '0;
  end

  // Mismatch statistics: saturating count, sticky flags, first snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      first_q <= '0;
    end else if (clr_stats) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      first_q <= '0;
    end else begin
      if (cnt_en && mismatch_i) begin
        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        err_q <= 1'b1;
        if (!err_q) first_q <= snap;
      end
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign running_o        = (state_q == Run);
  assign done_o           = (state_q == Done);
  assign error_o          = err_q;
  assign timeout_o        = tmo_q;
  assign mismatch_cnt_o   = cnt_q;
  assign first_mismatch_o = first_q;

endmodule
